// File: rtl/les_pkg.sv
// Shared definitions for the LES cipher cores.
// Word width, default round key, byte-rotate helpers, FSM encoding.
package les_pkg;

    localparam int LES_WORD_W = 32;
    localparam logic [LES_WORD_W-1:0] LES_KEY = 32'hDEADC0DE;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } les_state_e;

    function automatic logic [LES_WORD_W-1:0] rotr8(
        input logic [LES_WORD_W-1:0] x
    );
        return {x[7:0], x[LES_WORD_W-1:8]};
    endfunction

    function automatic logic [LES_WORD_W-1:0] rotl8(
        input logic [LES_WORD_W-1:0] x
    );
        return {x[LES_WORD_W-9:0], x[LES_WORD_W-1:LES_WORD_W-8]};
    endfunction

endpackage

// File: rtl/aes_sbox_lut.sv
// AES byte substitution, forward (dec=0) or inverse (dec=1).
// Built from the GF(2^8) inverse and the affine map.
module aes_sbox_lut (
    input  logic       dec,
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] gf_mul(
        input logic [7:0] a,
        input logic [7:0] b
    );
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 is the multiplicative inverse; it maps 0 to 0 as AES needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rol(
        input logic [7:0] x,
        input int         n
    );
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] aff(input logic [7:0] x);
        return x ^ rol(x, 1) ^ rol(x, 2) ^ rol(x, 3) ^ rol(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return rol(x, 1) ^ rol(x, 3) ^ rol(x, 6) ^ 8'h05;
    endfunction

    // Pick forward or inverse substitution.
    always_comb begin
        dout = dec ? gf_inv(aff_inv(din)) : aff(gf_inv(din));
    end

endmodule

// File: rtl/les_dec_round.sv
// One LES decryption round: rotate right by a byte,
// forward S-box on each byte, then XOR with the round key.
module les_dec_round
    import les_pkg::*;
#(
    parameter logic [LES_WORD_W-1:0] KEY = LES_KEY
) (
    input  logic [LES_WORD_W-1:0] rin,
    output logic [LES_WORD_W-1:0] rout
);

    logic [LES_WORD_W-1:0] r;
    logic [LES_WORD_W-1:0] s;

    assign r = rotr8(rin);

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox_lut u_sbox (
            .dec  (1'b0),
            .din  (r[8*b +: 8]),
            .dout (s[8*b +: 8])
        );
    end

    assign rout = s ^ KEY;

endmodule

// File: rtl/les_dec_top.sv
// Iterative LES decryption core: ROUNDS applications of G per word.
// Optional LES_DEC_LEAK_AMP_EN adds power-signature buffer chains.
module les_dec_top
    import les_pkg::*;
#(
    parameter logic [LES_WORD_W-1:0] KEY    = LES_KEY,
    parameter int                    ROUNDS = 4
) (
    input  logic                  clk,
    input  logic                  clr_n,
    input  logic [LES_WORD_W-1:0] ciphertext_in,
    input  logic                  start,
    output logic [LES_WORD_W-1:0] plaintext_out,
    output logic                  busy,
    output logic                  done
);

    localparam logic [3:0] LAST = 4'(ROUNDS - 1);

    les_state_e            state_q, state_d;
    logic [LES_WORD_W-1:0] text_q, text_d;
    logic [3:0]            rnd_q, rnd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [LES_WORD_W-1:0] g_in;
    logic [LES_WORD_W-1:0] g_out;

    assign g_in = (state_q == RUN) ? text_q : ciphertext_in;

    les_dec_round #(
        .KEY (KEY)
    ) u_round (
        .rin  (g_in),
        .rout (g_out)
    );

    // Next state: accept in IDLE, iterate in RUN, pulse done on last round.
    always_comb begin
        state_d = state_q;
        text_d  = text_q;
        rnd_d   = rnd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    text_d = g_out;
                    if (ROUNDS == 1) begin
                        done_d = 1'b1;
                    end else begin
                        rnd_d   = 4'd1;
                        busy_d  = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                text_d = g_out;
                rnd_d  = rnd_q + 4'd1;
                if (rnd_q == LAST) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= IDLE;
            text_q  <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            text_q  <= text_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign plaintext_out = text_q;
    assign busy          = busy_q;
    assign done          = done_q;

`ifdef LES_DEC_LEAK_AMP_EN
    for (genvar c = 0; c < 4; c++) begin : g_leak
        logic [64:0] chain;
        assign chain[0] = text_q[8*c];
        for (genvar s = 0; s < 64; s++) begin : g_stage
            (* keep *) SB_LUT4 #(
                .LUT_INIT (16'h0002)
            ) u_buf (
                .O  (chain[s+1]),
                .I0 (chain[s]),
                .I1 (1'b0),
                .I2 (1'b0),
                .I3 (1'b0)
            );
        end
    end
`endif

endmodule

// File: tb/tb_les_dec_top.sv
// Randomised bench for les_dec_top against a table-driven cipher model.
// Two instances: defaults, and KEY=0 with a single round.
module tb_les_dec_top;

    localparam logic [31:0] KEY = 32'hDEADC0DE;
    localparam int          NR  = 4;

    localparam logic [7:0] SBOX [256] = '{
        8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
        8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
        8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
        8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
        8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
        8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
        8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
        8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
        8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
        8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
        8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
        8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
        8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
        8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
        8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
        8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
    };

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] ct = '0;
    logic [31:0] pt;
    logic        busy;
    logic        done;
    logic        start1 = 1'b0;
    logic [31:0] ct1 = '0;
    logic [31:0] pt1;
    logic        busy1;
    logic        done1;

    logic [7:0] sinv [256];
    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    les_dec_top dut (
        .clk           (clk),
        .clr_n         (clr_n),
        .ciphertext_in (ct),
        .start         (start),
        .plaintext_out (pt),
        .busy          (busy),
        .done          (done)
    );

    les_dec_top #(
        .KEY    (32'h0),
        .ROUNDS (1)
    ) dut1 (
        .clk           (clk),
        .clr_n         (clr_n),
        .ciphertext_in (ct1),
        .start         (start1),
        .plaintext_out (pt1),
        .busy          (busy1),
        .done          (done1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", tag, got, exp);
    endtask

    function automatic logic [31:0] sub(input logic [31:0] x, input bit inv);
        logic [31:0] y;
        for (int b = 0; b < 4; b++)
            y[8*b +: 8] = inv ? sinv[x[8*b +: 8]] : SBOX[x[8*b +: 8]];
        return y;
    endfunction

    function automatic logic [31:0] g_ref(input logic [31:0] y, input logic [31:0] k);
        return sub({y[7:0], y[31:8]}, 1'b0) ^ k;
    endfunction

    function automatic logic [31:0] f_ref(input logic [31:0] x, input logic [31:0] k);
        logic [31:0] t;
        t = sub(x ^ k, 1'b1);
        return {t[23:0], t[31:24]};
    endfunction

    function automatic logic [31:0] dec_ref(input logic [31:0] c);
        logic [31:0] v = c;
        for (int i = 0; i < NR; i++) v = g_ref(v, KEY);
        return v;
    endfunction

    function automatic logic [31:0] enc_ref(input logic [31:0] p);
        logic [31:0] v = p;
        for (int i = 0; i < NR; i++) v = f_ref(v, KEY);
        return v;
    endfunction

    task automatic run_op(input string tag, input logic [31:0] c,
                          input logic [31:0] exp, input int inj);
        int first = 0;
        int nb = 0;
        int nd = 0;
        @(negedge clk);
        ct = c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                if (first == 0) begin
                    first = k;
                    chk({tag, " result"}, pt, exp);
                end
            end
            if (inj != 0 && k == inj) begin
                start = 1'b1;
                ct = ~c;
            end else if (inj != 0 && k == inj + 1) begin
                start = 1'b0;
            end
        end
        chk({tag, " done latency"}, 32'(first), 32'(NR));
        chk({tag, " busy cycles"}, 32'(nb), 32'(NR - 1));
        chk({tag, " done count"}, 32'(nd), 32'd1);
    endtask

    task automatic run_r1(input string tag, input logic [31:0] c,
                          input logic [31:0] exp);
        @(negedge clk);
        ct1 = c;
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        @(negedge clk);
        chk({tag, " result"}, pt1, exp);
        chk({tag, " done"}, 32'(done1), 32'd1);
        chk({tag, " busy"}, 32'(busy1), 32'd0);
        @(negedge clk);
        chk({tag, " done clr"}, 32'(done1), 32'd0);
        chk({tag, " busy idle"}, 32'(busy1), 32'd0);
    endtask

    initial begin
        logic [31:0] c;
        logic [31:0] c2;
        logic [31:0] rt [3];
        int nd;
        for (int i = 0; i < 256; i++) sinv[SBOX[i]] = 8'(i);

        repeat (2) @(negedge clk);
        chk("rst pt", pt, 32'h0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst pt1", pt1, 32'h0);
        clr_n = 1'b1;
        @(negedge clk);
        chk("post rst busy", 32'(busy), 32'd0);
        chk("post rst done", 32'(done), 32'd0);

        run_r1("r1 zero", 32'h0, 32'h63636363);
        run_r1("r1 inv", 32'h00000052, 32'h00636363);
        for (int i = 0; i < 4; i++) begin
            c = $urandom;
            run_r1("r1 rand", c, g_ref(c, 32'h0));
        end

        rt[0] = 32'h00000000;
        rt[1] = 32'h01234567;
        rt[2] = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++)
            run_op("round trip", enc_ref(rt[i]), rt[i], 0);

        for (int i = 0; i < 6; i++) begin
            c = $urandom;
            run_op("rand", c, dec_ref(c), 0);
        end

        c = $urandom;
        run_op("ignored start", c, dec_ref(c), 2);

        c = $urandom;
        c2 = $urandom;
        nd = 0;
        @(negedge clk);
        ct = c;
        start = 1'b1;
        @(posedge clk);
        #1 ct = c2;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done) nd++;
            if (k == 4) begin
                chk("b2b first done", 32'(done), 32'd1);
                chk("b2b first result", pt, dec_ref(c));
            end
            if (k == 5) begin
                chk("b2b second accept", 32'(busy), 32'd1);
                start = 1'b0;
            end
            if (k == 8) begin
                chk("b2b second done", 32'(done), 32'd1);
                chk("b2b second result", pt, dec_ref(c2));
            end
        end
        chk("b2b done count", 32'(nd), 32'd2);

        c = $urandom;
        @(negedge clk);
        ct = c;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(negedge clk);
        clr_n = 1'b0;
        #1;
        chk("midrst pt", pt, 32'h0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst done", 32'(done), 32'd0);
        @(negedge clk);
        clr_n = 1'b1;
        nd = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("midrst no done", 32'(nd), 32'd0);
        c = $urandom;
        run_op("after rst", c, dec_ref(c), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
